// File: rtl/jtbubl_snd_rstgen.sv
// Sound CPU reset generator: holds snd_rstn low while main requests it, then
// for RST_LEN further sound clock enables before releasing.
module jtbubl_snd_rstgen #(
  parameter int RST_LEN = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic snd_cen_i,
  input  logic req_i,
  input  logic req_val_i,
  output logic snd_rstn_o
);

  localparam int CW = $clog2(RST_LEN) + 1;
  localparam logic [CW-1:0] RST_INIT = CW'(RST_LEN);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold_q, hold_d;
  logic          rstn_q, rstn_d;

  always_comb begin
    cnt_d  = cnt_q;
    hold_d = hold_q;
    // The release countdown only runs once the main side has let go
    if (snd_cen_i && !hold_q && cnt_q != '0) cnt_d = cnt_q - CW'(1);
    if (req_i) begin
      hold_d = req_val_i;
      if (req_val_i) cnt_d = RST_INIT;
    end
    rstn_d = !hold_d && (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= RST_INIT;
      hold_q <= 1'b0;
      rstn_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hold_q <= hold_d;
      rstn_q <= rstn_d;
    end
  end

  assign snd_rstn_o = rstn_q;

endmodule

// File: rtl/jtbubl_snd_comm.sv
// Main<->sound CPU mailbox for JTBUBL: command/reply latches, pending flags,
// NMI generation towards the sound Z80 and the main-driven sound reset.
module jtbubl_snd_comm #(
  parameter int NMI_LEN = 4,
  parameter int RST_LEN = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       main_cen,
  input  logic       snd_cen,
  input  logic       main_we,
  input  logic [7:0] main_din,
  input  logic       main_rd,
  input  logic       main_rstreq,
  input  logic       main_rstval,
  output logic [7:0] main_reply,
  output logic [1:0] main_stat,
  input  logic       snd_rd,
  input  logic       snd_we,
  input  logic [7:0] snd_din,
  input  logic       snd_nmi_en,
  input  logic       snd_nmi_dis,
  output logic [7:0] snd_latch,
  output logic       snd_nmin,
  output logic       snd_rstn
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_ASSERT, ST_HOLD} nmi_st_e;

  localparam logic [3:0] NMI_INIT = 4'(NMI_LEN);

  nmi_st_e    st_q, st_d;
  logic [3:0] ncnt_q, ncnt_d;
  logic       req_q, req_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] reply_q, reply_d;
  logic       cmd_pend_q, cmd_pend_d;
  logic       reply_pend_q, reply_pend_d;
  logic       nmi_en_q, nmi_en_d;

  logic main_wr, main_ack, rst_set, snd_act;

  assign main_wr  = main_we & main_cen;
  assign main_ack = main_rd & main_cen;
  assign rst_set  = main_rstreq & main_cen & main_rstval;
  // Sound-side strobes are dead while the sound CPU is held in reset
  assign snd_act  = snd_cen & snd_rstn;

  jtbubl_snd_rstgen #(.RST_LEN(RST_LEN)) u_rstgen (
    .clk        (clk),
    .rst_n      (rst_n),
    .snd_cen_i  (snd_cen),
    .req_i      (main_rstreq & main_cen),
    .req_val_i  (main_rstval),
    .snd_rstn_o (snd_rstn)
  );

  always_comb begin
    st_d   = st_q;
    ncnt_d = ncnt_q;
    req_d  = req_q | main_wr;
    if (snd_cen) begin
      case (st_q)
        ST_IDLE: begin
          if (req_d) begin
            st_d  = ST_ARMED;
            req_d = 1'b0;
          end
        end
        ST_ARMED: begin
          req_d = 1'b0;
          if (nmi_en_q) begin
            st_d   = ST_ASSERT;
            ncnt_d = NMI_INIT;
          end
        end
        ST_ASSERT: begin
          if (ncnt_q != 4'd0) ncnt_d = ncnt_q - 4'd1;
          if (ncnt_q <= 4'd1) st_d = ST_HOLD;
        end
        ST_HOLD: begin
          st_d  = req_d ? ST_ARMED : ST_IDLE;
          req_d = 1'b0;
        end
        default: st_d = ST_IDLE;
      endcase
    end else if (st_q == ST_ARMED) begin
      // An armed NMI already covers any newer command; only the data changes
      req_d = 1'b0;
    end
    if (rst_set) begin
      st_d   = ST_IDLE;
      ncnt_d = 4'd0;
      req_d  = main_wr;
    end
  end

  always_comb begin
    cmd_d        = main_wr ? main_din : cmd_q;
    reply_d      = (snd_we & snd_act) ? snd_din : reply_q;

    cmd_pend_d   = cmd_pend_q;
    if (snd_rd & snd_act) cmd_pend_d = 1'b0;
    if (rst_set)          cmd_pend_d = 1'b0;
    if (main_wr)          cmd_pend_d = 1'b1;

    reply_pend_d = reply_pend_q;
    if (main_ack)         reply_pend_d = 1'b0;
    if (snd_we & snd_act) reply_pend_d = 1'b1;

    nmi_en_d     = nmi_en_q;
    if (snd_act) begin
      if (snd_nmi_en)  nmi_en_d = 1'b1;
      if (snd_nmi_dis) nmi_en_d = 1'b0;
    end
    if (rst_set) nmi_en_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q         <= ST_IDLE;
      ncnt_q       <= 4'd0;
      req_q        <= 1'b0;
      cmd_q        <= 8'd0;
      reply_q      <= 8'd0;
      cmd_pend_q   <= 1'b0;
      reply_pend_q <= 1'b0;
      nmi_en_q     <= 1'b0;
    end else begin
      st_q         <= st_d;
      ncnt_q       <= ncnt_d;
      req_q        <= req_d;
      cmd_q        <= cmd_d;
      reply_q      <= reply_d;
      cmd_pend_q   <= cmd_pend_d;
      reply_pend_q <= reply_pend_d;
      nmi_en_q     <= nmi_en_d;
    end
  end

  assign snd_latch  = cmd_q;
  assign main_reply = reply_q;
  assign main_stat  = {reply_pend_q, cmd_pend_q};
  assign snd_nmin   = (st_q != ST_ASSERT);

endmodule
